// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone B4 pipelined initiator driven by a single-word
// valid/ready command channel. One transaction is outstanding at a time.
// Retry, error and timeout outcomes are reported on the response channel.
module wb_cmd_master #(
    parameter int ADR_W          = 30,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [31:0]      cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_timeout_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    input  logic             wb_stall_i
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RTY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);
    localparam bit               TMO_EN    = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RSP     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               we_q, we_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_tmo_q, rsp_tmo_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RTY_W-1:0]   rty_cnt_q, rty_cnt_d;

    // Next-state, bus request fields, counters and response fields.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        tmo_cnt_d = tmo_cnt_q;
        rty_cnt_d = rty_cnt_q;
        rsp_err_d = rsp_err_q;
        rsp_tmo_d = rsp_tmo_q;
        rsp_dat_d = rsp_dat_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d      = cmd_we_i;
                    adr_d     = cmd_adr_i;
                    sel_d     = cmd_sel_i;
                    dat_d     = cmd_dat_i;
                    tmo_cnt_d = {TMO_W{1'b0}};
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ, ST_WAIT: begin
                // cyc is high in both states, so terminations are live here.
                if (wb_err_i) begin
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b0;
                    rsp_dat_d = 32'h0000_0000;
                    state_d   = ST_RSP;
                end else if (wb_ack_i) begin
                    rsp_err_d = 1'b0;
                    rsp_tmo_d = 1'b0;
                    rsp_dat_d = we_q ? 32'h0000_0000 : wb_dat_i;
                    state_d   = ST_RSP;
                end else if (wb_rty_i) begin
                    if (rty_cnt_q < RTY_LIMIT) begin
                        rty_cnt_d = rty_cnt_q + {{(RTY_W-1){1'b0}}, 1'b1};
                        state_d   = ST_BACKOFF;
                    end else begin
                        rsp_err_d = 1'b1;
                        rsp_tmo_d = 1'b0;
                        rsp_dat_d = 32'h0000_0000;
                        state_d   = ST_RSP;
                    end
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    rsp_dat_d = 32'h0000_0000;
                    state_d   = ST_RSP;
                end else begin
                    if (TMO_EN) begin
                        tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
                    end else begin
                        tmo_cnt_d = tmo_cnt_q;
                    end
                    if ((state_q == ST_REQ) && !wb_stall_i) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            ST_BACKOFF: begin
                // One idle bus cycle, then re-issue the same request.
                tmo_cnt_d = {TMO_W{1'b0}};
                state_d   = ST_REQ;
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    rty_cnt_d = {RTY_W{1'b0}};
                    rsp_err_d = 1'b0;
                    rsp_tmo_d = 1'b0;
                    rsp_dat_d = 32'h0000_0000;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cyc_d       = (state_d == ST_REQ) || (state_d == ST_WAIT);
        stb_d       = (state_d == ST_REQ);
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
    end

    // State and registered outputs; async reset drops the bus immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            we_q        <= 1'b0;
            adr_q       <= {ADR_W{1'b0}};
            sel_q       <= 4'h0;
            dat_q       <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
            tmo_cnt_q   <= {TMO_W{1'b0}};
            rty_cnt_q   <= {RTY_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            cmd_ready_q <= cmd_ready_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            rsp_dat_q   <= rsp_dat_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rty_cnt_q   <= rty_cnt_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_sel_o      = sel_q;
    assign wb_dat_o      = dat_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_tmo_q;
    assign rsp_dat_o     = rsp_dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed testbench for wb_cmd_master (TIMEOUT_CYCLES=8, RETRY_MAX=2).
module tb_wb_cmd_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [29:0] cmd_adr_i;
    logic [3:0]  cmd_sel_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int acc_cnt   = 0;
    int acc_base;

    wb_cmd_master #(.ADR_W(30), .TIMEOUT_CYCLES(8), .RETRY_MAX(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    // Counts accepted strobes (stb high, stall low at a rising edge).
    always @(posedge clk_i) begin
        if (wb_stb_o && !wb_stall_i) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_sel_i   = sel;
        cmd_dat_i   = dat;
        tick;
        cmd_valid_i = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        chk(tag, 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 30'h0;
        cmd_sel_i = 4'h0; cmd_dat_i = 32'h0; rsp_ready_i = 1'b0; wb_dat_i = 32'h0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_wdat", wb_dat_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        rst_n_i = 1'b1;
        tick;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp_err_o, rsp_timeout_o}, 32'd0);

        // Termination while cyc is low is ignored
        wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        chk("idle_ack_ignored", 32'(rsp_valid_o), 32'd0);
        chk("idle_cyc", 32'(wb_cyc_o), 32'd0);

        // Read, stalled for 2 cycles, then stall drop with ack
        acc_base = acc_cnt;
        wb_stall_i = 1'b1;
        send(1'b0, 30'h100, 4'hF, 32'h0);
        chk("rd_cyc", 32'(wb_cyc_o), 32'd1);
        chk("rd_stb", 32'(wb_stb_o), 32'd1);
        chk("rd_adr", 32'(wb_adr_o), 32'h100);
        chk("rd_cmd_ready", 32'(cmd_ready_o), 32'd0);
        tick;
        chk("rd_stall_stb", 32'(wb_stb_o), 32'd1);
        tick;
        wb_stall_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h0012_3456;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rd_rsp_dat", rsp_dat_o, 32'h0012_3456);
        chk("rd_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rd_cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("rd_acc", 32'(acc_cnt - acc_base), 32'd1);
        handshake("rd_hs");
        chk("rd_idle_ready", 32'(cmd_ready_o), 32'd1);

        // Write, ack 2 cycles after acceptance
        acc_base = acc_cnt;
        send(1'b1, 30'h09, 4'hF, 32'h00FF_8040);
        chk("wr_stb", 32'(wb_stb_o), 32'd1);
        chk("wr_we", 32'(wb_we_o), 32'd1);
        tick;
        chk("wr_wait_stb", 32'(wb_stb_o), 32'd0);
        chk("wr_wait_cyc", 32'(wb_cyc_o), 32'd1);
        tick;
        chk("wr_adr_held", 32'(wb_adr_o), 32'h09);
        chk("wr_dat_held", wb_dat_o, 32'h00FF_8040);
        chk("wr_sel_held", 32'(wb_sel_o), 32'hF);
        chk("wr_we_held", 32'(wb_we_o), 32'd1);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("wr_rsp_dat", rsp_dat_o, 32'd0);
        chk("wr_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("wr_acc", 32'(acc_cnt - acc_base), 32'd1);
        handshake("wr_hs");

        // Error at acceptance of a read
        send(1'b0, 30'h20, 4'h3, 32'h0);
        wb_err_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
        tick;
        wb_err_i = 1'b0; wb_dat_i = 32'h0;
        chk("err_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("err_rsp_tmo", 32'(rsp_timeout_o), 32'd0);
        chk("err_rsp_dat", rsp_dat_o, 32'd0);
        chk("err_cyc", 32'(wb_cyc_o), 32'd0);
        handshake("err_hs");

        // Timeout: cyc high for 8 cycles
        send(1'b0, 30'h30, 4'hF, 32'h0);
        repeat (7) tick;
        chk("tmo_cyc_last", 32'(wb_cyc_o), 32'd1);
        tick;
        chk("tmo_cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("tmo_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("tmo_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("tmo_rsp_tmo", 32'(rsp_timeout_o), 32'd1);
        chk("tmo_rsp_dat", rsp_dat_o, 32'd0);
        handshake("tmo_hs");

        // Ack on the expiry edge wins over the timeout
        send(1'b0, 30'h31, 4'hF, 32'h0);
        repeat (7) tick;
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("tmoack_err", 32'(rsp_err_o), 32'd0);
        chk("tmoack_tmo", 32'(rsp_timeout_o), 32'd0);
        chk("tmoack_dat", rsp_dat_o, 32'h0BAD_F00D);
        handshake("tmoack_hs");

        // rty, rty, ack
        acc_base = acc_cnt;
        send(1'b0, 30'h44, 4'hF, 32'h0);
        wb_rty_i = 1'b1;
        tick;
        wb_rty_i = 1'b0;
        chk("rty1_backoff_cyc", 32'(wb_cyc_o), 32'd0);
        tick;
        chk("rty1_reissue_stb", 32'(wb_stb_o), 32'd1);
        chk("rty1_reissue_adr", 32'(wb_adr_o), 32'h44);
        wb_rty_i = 1'b1;
        tick;
        wb_rty_i = 1'b0;
        chk("rty2_backoff_cyc", 32'(wb_cyc_o), 32'd0);
        tick;
        chk("rty2_reissue_stb", 32'(wb_stb_o), 32'd1);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("rty_ok_err", 32'(rsp_err_o), 32'd0);
        chk("rty_ok_dat", rsp_dat_o, 32'h1111_2222);
        chk("rty_ok_acc", 32'(acc_cnt - acc_base), 32'd3);
        handshake("rty_ok_hs");

        // Three rty in a row: error after the third, no fourth attempt
        acc_base = acc_cnt;
        send(1'b0, 30'h45, 4'hF, 32'h0);
        wb_rty_i = 1'b1; tick; wb_rty_i = 1'b0; tick;
        wb_rty_i = 1'b1; tick; wb_rty_i = 1'b0; tick;
        wb_rty_i = 1'b1; tick; wb_rty_i = 1'b0;
        chk("rtyx_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rtyx_err", 32'(rsp_err_o), 32'd1);
        chk("rtyx_tmo", 32'(rsp_timeout_o), 32'd0);
        repeat (2) tick;
        chk("rtyx_no_reissue", 32'(wb_cyc_o), 32'd0);
        chk("rtyx_acc", 32'(acc_cnt - acc_base), 32'd3);
        handshake("rtyx_hs");

        // Response held 5 cycles while a new command waits
        send(1'b0, 30'h40, 4'hF, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_0001;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h1234_5678;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 30'h3F;
        cmd_sel_i = 4'h5; cmd_dat_i = 32'hA5A5_A5A5;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_dat", rsp_dat_o, 32'hCAFE_0001);
            chk("hold_err", 32'(rsp_err_o), 32'd0);
            chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
            tick;
        end
        handshake("hold_hs");
        chk("hold_idle_ready", 32'(cmd_ready_o), 32'd1);
        chk("hold_idle_cyc", 32'(wb_cyc_o), 32'd0);
        tick;
        cmd_valid_i = 1'b0;
        chk("next_cyc", 32'(wb_cyc_o), 32'd1);
        chk("next_adr", 32'(wb_adr_o), 32'h3F);
        chk("next_sel", 32'(wb_sel_o), 32'h5);
        wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("next_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("next_rsp_dat", rsp_dat_o, 32'd0);
        handshake("next_hs");

        // Reset during WAIT
        send(1'b0, 30'h55, 4'hF, 32'h0);
        tick;
        chk("rstw_wait_cyc", 32'(wb_cyc_o), 32'd1);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("rstw_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rstw_stb", 32'(wb_stb_o), 32'd0);
        chk("rstw_rsp_valid", 32'(rsp_valid_o), 32'd0);
        tick;
        rst_n_i = 1'b1;
        tick;
        chk("rstw_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rstw_adr", 32'(wb_adr_o), 32'd0);
        chk("rstw_cyc_after", 32'(wb_cyc_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone B4 pipelined initiator that turns single-word commands on a valid/ready interface into bus cycles towards CSR-style slaves such as the top-level register block.
- It serves debug/boot-loader paths, for example a UART command parser poking CSRs, which must act as bus master rather than slave.
- One transaction is outstanding at a time.
- Retry, error and timeout are all reported on a response channel.

Parameters:
- ADR_W, 30: width of the word address (byte address bits [ADR_W+1:2]).
- TIMEOUT_CYCLES, 255: cycles per attempt before abort, counted from the first stb cycle. 0 disables the timeout.
- RETRY_MAX, 3: number of rty re-issues allowed before the command is reported as error.

Ports:
- clk_i  in  1  system clock, all logic on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block can accept a command (high only in IDLE).
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADR_W  word address.
- cmd_sel_i  in  4  byte selects.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data; 0 for writes, errors and timeouts.
- rsp_err_o  out  1  err, retry exhaustion or timeout.
- rsp_timeout_o  out  1  abort was caused by the timeout.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADR_W  word address.
- wb_sel_o  out  4  byte selects.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- wb_rty_i  in  1  retry.
- wb_stall_i  in  1  stall.

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE; wb_cyc_o=0, wb_stb_o=0, wb_we_o=0.
  - wb_adr_o, wb_sel_o, wb_dat_o = 0.
  - rsp_valid_o=0, rsp_err_o=0, rsp_timeout_o=0, rsp_dat_o=0.
  - Retry and timeout counters = 0.
  - cmd_ready_o=1 once in IDLE.
- States: IDLE, REQ, WAIT, BACKOFF, RSP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i at an edge: latch we/adr/sel/dat into the wb_* output registers, clear the timeout counter, go to REQ.
  - Cycle N+1 after acceptance has wb_cyc_o=wb_stb_o=1.
- REQ (cyc=1, stb=1):
  - The request is accepted at an edge where wb_stall_i=0.
  - If no termination is seen at that edge, go to WAIT (stb=0, cyc=1).
  - ack/err/rty sampled in the same cycle as acceptance is valid and handled immediately. The CSR slaves drop stall and assert ack together, so this path is mandatory.
- Termination: sampled only while cyc=1, otherwise ignored. Priority is err > ack > rty.
  - err: go to RSP with err=1, dat=0.
  - ack: go to RSP with err=0. rsp_dat_o is the wb_dat_i captured at the ack edge for reads, 0 for writes.
  - rty with retry count < RETRY_MAX: increment the count, go to BACKOFF.
  - rty with retry count = RETRY_MAX: go to RSP with err=1, timeout=0.
- BACKOFF:
  - cyc=0 and stb=0 for exactly 1 cycle.
  - Then REQ with identical adr/dat/sel/we and the timeout counter cleared.
- Timeout:
  - Counter increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES with no termination at that edge: go to RSP with err=1, timeout=1, dat=0.
  - A termination arriving at the same edge as expiry wins over the timeout.
- Bus release:
  - cyc and stb are 0 in the cycle after termination or timeout.
  - cyc never stays high in RSP or IDLE.
- RSP:
  - rsp_valid_o=1 and all rsp_* fields stable until an edge with rsp_ready_i=1.
  - Then go to IDLE and clear the retry count.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- Minimum latency, with no stall and ack at the acceptance edge: cmd accepted at edge N, stb high in cycle N+1, ack at edge N+1, rsp_valid_o high in cycle N+2.
- The address is not decoded and there is no byte-lane manipulation; cmd_sel_i passes through.
- Reset mid-transaction drops cyc/stb immediately (async) and discards the pending command and response.

Test Plan:
- Read, slave holds stall=1 for 2 cycles then stall=0 with ack=1 and wb_dat_i=0x00123456 -> a single stb acceptance; rsp_valid_o with rsp_dat_o=0x00123456, err=0; cyc low the next cycle.
- Write adr=0x09, dat=0x00FF8040, sel=0xF, stall=0, ack 2 cycles after acceptance -> wb_* fields held for the whole cycle; stb high for exactly 1 cycle; rsp_dat_o=0, err=0.
- wb_err_i=1 at acceptance of a read -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
- TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles; rsp_err_o=1, rsp_timeout_o=1. Repeat with ack on the expiry edge -> normal ack response.
- RETRY_MAX=2: rty, rty, then ack -> three stb acceptances, each separated by one cyc=0 cycle, final err=0. Three rty in a row -> err=1 after the third, with no fourth attempt.
- rsp_ready_i held low for 5 cycles -> rsp fields stable and cmd_ready_o=0 throughout. Separately, assert rst_n_i=0 during WAIT -> cyc/stb/rsp_valid_o go to 0 asynchronously and cmd_ready_o=1 after release.
